// File: rtl/cond_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cond_exec_ctrl
// Brief   : E-stage conditional-execution controller: NZCV flags, cond-field
//           gating of writes/branches, post-branch squash window, statistics.
// Revision: 1.0
// ============================================================================
module cond_exec_ctrl #(
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_w_e,
    input  logic [3:0]       alu_flags_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             pc_src_e,
    input  logic             no_write_e,
    output logic             cond_ex_e,
    output logic             reg_write_g,
    output logic             mem_write_g,
    output logic             pc_src_g,
    output logic             squash_o,
    output logic             illegal_cond,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    state_t           state_q;
    logic [2:0]       sq_cnt_q;
    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] skip_cnt_q;
    logic [3:0]       flags_d;
    logic             valid;
    logic             cond_result;
    logic             ge;

    assign squash_o = (state_q == SQUASH);
    assign valid    = ~flush_e & ~squash_o;
    assign ge       = (flags_q[3] == flags_q[0]);

    // Evaluated against the committed flags only; ALU flags of this cycle never forward.
    always_comb begin
        cond_result = 1'b0;
        case (cond_e)
            4'b0000: cond_result = flags_q[2];
            4'b0001: cond_result = ~flags_q[2];
            4'b0010: cond_result = flags_q[1];
            4'b0011: cond_result = ~flags_q[1];
            4'b0100: cond_result = flags_q[3];
            4'b0101: cond_result = ~flags_q[3];
            4'b0110: cond_result = flags_q[0];
            4'b0111: cond_result = ~flags_q[0];
            4'b1000: cond_result = flags_q[1] & ~flags_q[2];
            4'b1001: cond_result = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: cond_result = ge;
            4'b1011: cond_result = ~ge;
            4'b1100: cond_result = ~flags_q[2] & ge;
            4'b1101: cond_result = ~(~flags_q[2] & ge);
            4'b1110: cond_result = 1'b1;
            default: cond_result = 1'b0;
        endcase
    end

    assign cond_ex_e    = cond_result & valid;
    assign reg_write_g  = reg_write_e & cond_ex_e & ~no_write_e;
    assign mem_write_g  = mem_write_e & cond_ex_e;
    assign pc_src_g     = pc_src_e & cond_ex_e;
    assign illegal_cond = (cond_e == 4'b1111) & valid;

    always_comb begin
        flags_d = flags_q;
        if (cond_ex_e) begin
            if (flag_w_e[1]) flags_d[3:2] = alu_flags_e[3:2];
            if (flag_w_e[0]) flags_d[1:0] = alu_flags_e[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sq_cnt_q   <= 3'd0;
            flags_q    <= 4'b0000;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else if (!stall_e) begin
            flags_q <= flags_d;
            case (state_q)
                IDLE: begin
                    if (pc_src_g) begin
                        state_q  <= SQUASH;
                        sq_cnt_q <= SQ_LOAD;
                    end
                end
                SQUASH: begin
                    sq_cnt_q <= sq_cnt_q - 3'd1;
                    if (sq_cnt_q <= 3'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Statistics saturate so long runs never wrap back to small values.
            if (cond_ex_e && (exec_cnt_q != {CNT_W{1'b1}})) begin
                exec_cnt_q <= exec_cnt_q + 1'b1;
            end
            if (valid && !cond_ex_e && (skip_cnt_q != {CNT_W{1'b1}})) begin
                skip_cnt_q <= skip_cnt_q + 1'b1;
            end
        end
    end

    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;

endmodule
`default_nettype wire
